cp_strip: RTL and testbench

//  Receive-side cyclic-prefix removal: counterpart of add_cp in the OFDM chain. Takes a stream of
//  CP+N sample symbols framed by isop/ival, discards the prefix (with optional FFT-window back-off

---
 rtl/cp_strip.sv | 117 +++++++++++
 tb/tb_cp_strip.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cp_strip.sv
// cp_strip - receive-side cyclic-prefix removal: drops CP (minus back-off), forwards FFT_SIZE samples
// with one-cycle registered latency and flags symbols cut short by an early isop.
module cp_strip #(
  parameter int WIDTH    = 12,
  parameter int FFT_SIZE = 1024,
  parameter int CP_LEN   = 32,
  parameter int BACKOFF  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isop,
  input  logic             ival,
  input  logic [WIDTH-1:0] in_real_data,
  input  logic [WIDTH-1:0] in_imag_data,
  output logic             osop,
  output logic             oeop,
  output logic             oval,
  output logic [WIDTH-1:0] out_real_data,
  output logic [WIDTH-1:0] out_imag_data,
  output logic             oerr
);

  localparam int TOTAL = FFT_SIZE + CP_LEN;
  localparam int CW    = $clog2(TOTAL);
  localparam int S     = CP_LEN - BACKOFF;

  localparam logic [CW-1:0] FIRST_OUT = CW'(S);
  localparam logic [CW-1:0] LAST_SKIP = CW'(S - 1);
  localparam logic [CW-1:0] LAST_OUT  = CW'(S + FFT_SIZE - 1);
  localparam logic [CW-1:0] LAST_IN   = CW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, SKIP, PASS, TAIL} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              osop_q, osop_d;
  logic              oeop_q, oeop_d;
  logic              oval_q, oval_d;
  logic              oerr_q, oerr_d;
  logic [WIDTH-1:0]  ore_q, ore_d;
  logic [WIDTH-1:0]  oim_q, oim_d;

  // idx_q holds the index the next accepted sample will take within the current symbol.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    osop_d  = 1'b0;
    oeop_d  = 1'b0;
    oval_d  = 1'b0;
    oerr_d  = 1'b0;
    if (ival) begin
      if (isop) begin
        // Any isop outside IDLE truncates the running symbol; this sample restarts at i=0.
        oerr_d  = (state_q != IDLE);
        idx_d   = CW'(1);
        state_d = (S == 1) ? PASS : SKIP;
      end else begin
        idx_d = idx_q + CW'(1);
        case (state_q)
          IDLE: idx_d = '0;
          SKIP: if (idx_q == LAST_SKIP) state_d = PASS;
          PASS: begin
            oval_d = 1'b1;
            osop_d = (idx_q == FIRST_OUT);
            oeop_d = (idx_q == LAST_OUT);
            if (idx_q == LAST_OUT) begin
              state_d = (BACKOFF == 0) ? IDLE : TAIL;
              if (BACKOFF == 0) idx_d = '0;
            end
          end
          TAIL: begin
            if (idx_q == LAST_IN) begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
          default: begin
            state_d = IDLE;
            idx_d   = '0;
          end
        endcase
      end
    end
    ore_d = oval_d ? in_real_data : '0;
    oim_d = oval_d ? in_imag_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oval_q  <= 1'b0;
      oerr_q  <= 1'b0;
      ore_q   <= '0;
      oim_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oval_q  <= oval_d;
      oerr_q  <= oerr_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
    end
  end

  assign osop          = osop_q;
  assign oeop          = oeop_q;
  assign oval          = oval_q;
  assign oerr          = oerr_q;
  assign out_real_data = ore_q;
  assign out_imag_data = oim_q;

endmodule

// File: tb/tb_cp_strip.sv
// tb_cp_strip - scoreboard bench for cp_strip with BACKOFF=0 and BACKOFF=8 instances sharing one stimulus.
module tb_cp_strip;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, isop, ival;
  logic [11:0] in_re, in_im;

  logic        s0, e0, v0, r0;
  logic [11:0] re0, im0;
  logic        s8, e8, v8, r8;
  logic [11:0] re8, im8;

  cp_strip #(.WIDTH(12), .FFT_SIZE(1024), .CP_LEN(32), .BACKOFF(0)) dut0 (
    .clk(clk), .rst(rst), .isop(isop), .ival(ival),
    .in_real_data(in_re), .in_imag_data(in_im),
    .osop(s0), .oeop(e0), .oval(v0),
    .out_real_data(re0), .out_imag_data(im0), .oerr(r0));

  cp_strip #(.WIDTH(12), .FFT_SIZE(1024), .CP_LEN(32), .BACKOFF(8)) dut8 (
    .clk(clk), .rst(rst), .isop(isop), .ival(ival),
    .in_real_data(in_re), .in_imag_data(in_im),
    .osop(s8), .oeop(e8), .oval(v8),
    .out_real_data(re8), .out_imag_data(im8), .oerr(r8));

  typedef struct {
    int          cyc;
    logic        sop;
    logic        eop;
    logic        err;
    logic [11:0] re;
    logic [11:0] im;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input exp_t x);
    if (d == 0) q0.push_back(x);
    else q8.push_back(x);
  endtask

  // Drives one cycle of input and records what each instance must emit one cycle later.
  task automatic send(input logic s, input logic v, input int idx,
                      input logic [11:0] re, input logic [11:0] im, input bit err_exp);
    exp_t x;
    int   st;
    @(posedge clk);
    #1;
    isop = s; ival = v; in_re = re; in_im = im;
    if (err_exp) begin
      x = '{cyc: cyc + 1, sop: 1'b0, eop: 1'b0, err: 1'b1, re: 12'h0, im: 12'h0};
      push(0, x);
      push(8, x);
    end
    if (v && idx >= 0) begin
      for (int d = 0; d <= 8; d += 8) begin
        st = 32 - d;
        if (idx >= st && idx <= st + 1023) begin
          x = '{cyc: cyc + 1, sop: (idx == st), eop: (idx == st + 1023), err: 1'b0, re: re, im: im};
          push(d, x);
        end
      end
    end
  endtask

  // Sends samples 0..n-1 of a symbol (data=i); gap>0 drops ival (with a stray isop) every gap-th cycle.
  task automatic symbol(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0 && (i % (gap - 1)) == 0)
        send(1'b1, 1'b0, -1, 12'hABC, 12'h123, 1'b0);
      send(i == 0, 1'b1, i, 12'(i), 12'(i) ^ 12'h5A5, (i == 0) && pending);
    end
    pending = (n < 1056);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, -1, 12'h0, 12'h0, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({s0, e0, v0, r0, re0, im0} !== 28'h0) begin
      errors++;
      $display("FAIL %s b0: outputs=%h required 0", name, {s0, e0, v0, r0, re0, im0});
    end
    checks++;
    if ({s8, e8, v8, r8, re8, im8} !== 28'h0) begin
      errors++;
      $display("FAIL %s b8: outputs=%h required 0", name, {s8, e8, v8, r8, re8, im8});
    end
  endtask

  task automatic mon(input int d, input logic v, input logic s, input logic e, input logic r,
                     input logic [11:0] re, input logic [11:0] im);
    exp_t x;
    int   n;
    n = (d == 0) ? q0.size() : q8.size();
    while (n > 0) begin
      x = (d == 0) ? q0[0] : q8[0];
      if (x.cyc >= cyc) break;
      checks++;
      errors++;
      $display("FAIL missing b%0d: cycle %0d saw nothing, required err=%0b data=%h", d, x.cyc, x.err, x.re);
      if (d == 0) void'(q0.pop_front());
      else void'(q8.pop_front());
      n--;
    end
    checks++;
    if (v || r) begin
      if (n == 0 || x.cyc != cyc) begin
        errors++;
        $display("FAIL unexpected b%0d: cycle %0d val=%0b err=%0b data=%h, required idle", d, cyc, v, r, re);
      end else begin
        if (d == 0) void'(q0.pop_front());
        else void'(q8.pop_front());
        if ({v, s, e, r, re, im} !== {!x.err, x.sop, x.eop, x.err, x.re, x.im}) begin
          errors++;
          $display("FAIL output b%0d cycle %0d: val/sop/eop/err=%0b%0b%0b%0b re=%h im=%h, required %0b%0b%0b%0b re=%h im=%h",
                   d, cyc, v, s, e, r, re, im, !x.err, x.sop, x.eop, x.err, x.re, x.im);
        end
      end
    end else if (s || e || re != 12'h0 || im != 12'h0) begin
      errors++;
      $display("FAIL idle_zero b%0d cycle %0d: sop=%0b eop=%0b re=%h im=%h, required 0", d, cyc, s, e, re, im);
    end
  endtask

  always @(negedge clk) begin
    mon(0, v0, s0, e0, r0, re0, im0);
    mon(8, v8, s8, e8, r8, re8, im8);
  end

  initial begin
    rst = 1'b1; isop = 1'b0; ival = 1'b0; in_re = 12'h0; in_im = 12'h0;
    #2 rst = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Samples without isop while idle are discarded.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, -1, 12'hFFF, 12'hFFF, 1'b0);
    idle(3);

    symbol(1056, 0);
    idle(10);
    symbol(1056, 0);
    symbol(1056, 0);
    idle(10);
    symbol(1056, 3);
    idle(10);
    symbol(500, 0);
    symbol(1056, 0);
    idle(10);

    symbol(700, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0; ival = 1'b0; isop = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    pending = 0;
    idle(2);
    symbol(1056, 0);
    idle(12);

    checks++;
    if (q0.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: pending b0=%0d b8=%0d, required 0", q0.size(), q8.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
